// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder sequencer.
package serial_add_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage : serial_add_pkg

// File: rtl/bit_adder.sv
// One-bit full adder built from two half adders and an OR.
module bit_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   logic p;
   logic g0;
   logic g1;

   half_adder u_ha0 (.a(a), .b(b),   .s(p), .c(g0));
   half_adder u_ha1 (.a(p), .b(cin), .s(s), .c(g1));

   // Carry out: generate from the operands or propagate the incoming carry
   always_comb begin
      co = g0 | g1;
   end

endmodule : bit_adder

// File: rtl/half_adder.sv
// One-bit half adder: building block of the shared full-adder cell.
module half_adder (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);

   // Sum and carry of two bits
   always_comb begin
      s = a ^ b;
      c = a & b;
   end

endmodule : half_adder

// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: one full-adder cell stepped LSB-first over WIDTH bits.
module serial_add_seq
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // One extra bit keeps WIDTH=1 and power-of-two widths from wrapping early
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic cell_s;
   logic cell_co;

   bit_adder u_cell (
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .cin(carry_q),
      .s  (cell_s),
      .co (cell_co)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sh_q  <= a_sh_d;
         b_sh_q  <= b_sh_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state, shift datapath and registered status flags
   always_comb begin
      state_d = state_q;
      a_sh_d  = a_sh_q;
      b_sh_d  = b_sh_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d  = a;
               b_sh_d  = b;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            sum_d            = sum_q >> 1;
            sum_d[WIDTH-1]   = cell_s;
            a_sh_d           = a_sh_q >> 1;
            b_sh_d           = b_sh_q >> 1;
            carry_d          = cell_co;
            cnt_d            = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               cout_d  = cell_co;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule : serial_add_seq

// File: tb/tb_serial_add_seq.sv
// Directed and random checks of serial_add_seq at WIDTH 8, 4 and 1.
module tb_serial_add_seq;

   logic clk;
   logic rst_n;

   logic       start8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start4, busy4, done4, cout4;
   logic [3:0] a4, b4, sum4;
   logic       start1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   int checks;
   int failures;

   serial_add_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );
   serial_add_seq #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );
   serial_add_seq #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launch one 8-bit add and collect what was observed (no comparisons here)
   task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                      output logic [7:0] s, output logic c,
                      output int lat, output logic pulse_ok);
      @(negedge clk);
      a8 = av; b8 = bv; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = ~av; b8 = ~bv;
      lat = 0;
      while (!done8 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      s = sum8;
      c = cout8;
      @(negedge clk);
      pulse_ok = !done8 && !busy8;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start8 = 0; a8 = 8'h5A; b8 = 8'hC3;
      start4 = 0; a4 = '0; b4 = '0;
      start1 = 0; a1 = '0; b1 = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy8, done8, sum8, cout8} !== 11'd0) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b want all zero",
                  busy8, done8, sum8, cout8);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy8 !== 1'b0 || sum8 !== 8'h00) begin
         failures++;
         $display("FAIL idle_after_reset: got busy=%b sum=%h want 0 00", busy8, sum8);
      end
   endtask

   // 05+03 with cycle-by-cycle timing of busy and done
   task automatic test_basic_timing();
      bit timing_ok;
      @(negedge clk);
      a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
      @(negedge clk);                         // after E0
      start8 = 1'b0;
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
         failures++;
         $display("FAIL busy_after_E0: got busy=%b done=%b want 1 0", busy8, done8);
      end
      timing_ok = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (busy8 !== 1'b1 || done8 !== 1'b0) timing_ok = 1'b0;
      end
      checks++;
      if (!timing_ok) begin
         failures++;
         $display("FAIL shift_phase: busy/done wrong during E1..E7");
      end
      @(negedge clk);                         // after E8
      checks++;
      if (done8 !== 1'b1 || busy8 !== 1'b1 || sum8 !== 8'h08 || cout8 !== 1'b0) begin
         failures++;
         $display("FAIL done_05_03: got done=%b busy=%b sum=%h cout=%b want 1 1 08 0",
                  done8, busy8, sum8, cout8);
      end
      @(negedge clk);                         // after E9
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h08) begin
         failures++;
         $display("FAIL back_to_idle: got done=%b busy=%b sum=%h want 0 0 08",
                  done8, busy8, sum8);
      end
   endtask

   task automatic test_vectors();
      logic [7:0] s; logic c; int lat; logic p;
      op8(8'hFF, 8'h01, s, c, lat, p);
      checks++;
      if ({c, s} !== 9'h100 || lat !== 8 || p !== 1'b1) begin
         failures++;
         $display("FAIL add_FF_01: got cout=%b sum=%h lat=%0d pulse=%b want 1 00 8 1", c, s, lat, p);
      end
      op8(8'hA5, 8'h5A, s, c, lat, p);
      checks++;
      if ({c, s} !== 9'h0FF || lat !== 8 || p !== 1'b1) begin
         failures++;
         $display("FAIL add_A5_5A: got cout=%b sum=%h lat=%0d pulse=%b want 0 FF 8 1", c, s, lat, p);
      end
   endtask

   // Start while busy is ignored; held-high start re-accepts at E10
   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
      @(negedge clk);                         // after E0
      start8 = 1'b0;
      repeat (2) @(negedge clk);              // after E2
      a8 = 8'hFF; start8 = 1'b1;              // seen at E3 and held
      repeat (6) @(negedge clk);              // after E8
      checks++;
      if (done8 !== 1'b1 || sum8 !== 8'h30 || cout8 !== 1'b0) begin
         failures++;
         $display("FAIL ignore_start_busy: got done=%b sum=%h cout=%b want 1 30 0",
                  done8, sum8, cout8);
      end
      @(negedge clk);                         // after E9
      checks++;
      if (busy8 !== 1'b0) begin
         failures++;
         $display("FAIL idle_at_E9: got busy=%b want 0", busy8);
      end
      @(negedge clk);                         // after E10
      start8 = 1'b0;
      checks++;
      if (busy8 !== 1'b1) begin
         failures++;
         $display("FAIL reaccept_E10: got busy=%b want 1", busy8);
      end
      lat = 0;
      while (!done8 && lat < 30) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 8 || sum8 !== 8'h1F || cout8 !== 1'b1) begin
         failures++;
         $display("FAIL second_op_FF_20: got lat=%0d sum=%h cout=%b want 8 1F 1",
                  lat, sum8, cout8);
      end
      @(negedge clk);
   endtask

   task automatic test_async_reset();
      logic [7:0] s; logic c; int lat; logic p;
      bit saw_done;
      @(negedge clk);
      a8 = 8'h7E; b8 = 8'h93; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);              // after E4
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy8, done8, sum8, cout8} !== 11'd0) begin
         failures++;
         $display("FAIL async_reset: got busy=%b done=%b sum=%h cout=%b want all zero",
                  busy8, done8, sum8, cout8);
      end
      @(negedge clk);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done8 || busy8) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL no_done_after_reset: got activity=1 want 0");
      end
      op8(8'h7E, 8'h93, s, c, lat, p);
      checks++;
      if ({c, s} !== 9'h111 || lat !== 8 || p !== 1'b1) begin
         failures++;
         $display("FAIL fresh_after_reset: got cout=%b sum=%h lat=%0d pulse=%b want 1 11 8 1", c, s, lat, p);
      end
   endtask

   task automatic test_width4();
      int lat;
      @(negedge clk);
      a4 = 4'hF; b4 = 4'hF; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      lat = 0;
      while (!done4 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 4 || sum4 !== 4'hE || cout4 !== 1'b1) begin
         failures++;
         $display("FAIL width4_F_F: got lat=%0d sum=%h cout=%b want 4 E 1", lat, sum4, cout4);
      end
      @(negedge clk);
      checks++;
      if (done4 !== 1'b0 || busy4 !== 1'b0) begin
         failures++;
         $display("FAIL width4_idle: got done=%b busy=%b want 0 0", done4, busy4);
      end
   endtask

   task automatic test_width1();
      int lat;
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      lat = 0;
      while (!done1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== 1 || sum1 !== 1'b0 || cout1 !== 1'b1) begin
         failures++;
         $display("FAIL width1_1_1: got lat=%0d sum=%b cout=%b want 1 0 1", lat, sum1, cout1);
      end
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
         failures++;
         $display("FAIL width1_idle: got done=%b busy=%b want 0 0", done1, busy1);
      end
   endtask

   task automatic test_random();
      logic [7:0] av, bv, s;
      logic       c, p;
      logic [8:0] exp;
      int         lat;
      for (int i = 0; i < 1000; i++) begin
         av  = 8'($urandom);
         bv  = 8'($urandom);
         exp = 9'(av) + 9'(bv);
         op8(av, bv, s, c, lat, p);
         checks++;
         if ({c, s} !== exp || lat !== 8 || p !== 1'b1) begin
            failures++;
            $display("FAIL random_%0d: a=%h b=%h got %h lat=%0d pulse=%b want %h 8 1",
                     i, av, bv, {c, s}, lat, p, exp);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic_timing();
      test_vectors();
      test_back_to_back();
      test_async_reset();
      test_width4();
      test_width1();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_serial_add_seq
